// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: round-robin owner of the single 64-bit TRN transmit port.
// One packet engine holds the port for exactly one TLP; protocol violations raise sticky flags.
module pcie_tx_arb #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BEATS = 64
) (
    input  logic                  pcie_clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_v,
    input  logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic                  req_stall,
    input  logic [NUM_REQ*64-1:0] req_td,
    input  logic [NUM_REQ*8-1:0]  req_trem_n,
    input  logic [NUM_REQ-1:0]    req_tsof_n,
    input  logic [NUM_REQ-1:0]    req_teof_n,
    input  logic [NUM_REQ-1:0]    req_tsrc_rdy_n,
    output logic [63:0]           trn_td,
    output logic [7:0]            trn_trem_n,
    output logic                  trn_tsof_n,
    output logic                  trn_teof_n,
    output logic                  trn_tsrc_rdy_n,
    input  logic                  trn_tdst_rdy_n,
    input  logic [5:0]            trn_tbuf_av,
    output logic                  err_long,
    output logic                  err_done,
    input  logic                  err_clr
);

    // state | meaning
    // IDLE  | port free, arbitrating among requesters, trn_* forced idle
    // BUSY  | requester sel owns the port until its unstalled done

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BEATS + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_REQ-1:0] grant_q;
    logic [PW-1:0]      sel_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      win;
    logic               win_v;
    logic [CW-1:0]      cnt_q;
    logic               err_long_q;
    logic               err_done_q;
    logic               arb_go;
    logic               release_go;
    logic               beat;
    logic               long_set;
    logic               done_set;
    logic [NUM_REQ-1:0] owner_mask;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        win   = '0;
        win_v = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_v && req_v[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_v = 1'b1;
                win   = PW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        owner_mask = (state_q == BUSY) ? grant_q : '0;
        arb_go     = (state_q == IDLE) && win_v && (trn_tbuf_av != 6'd0);
        beat       = (state_q == BUSY) && !trn_tdst_rdy_n && !req_tsrc_rdy_n[sel_q];
        release_go = (state_q == BUSY) && req_done[sel_q] && !trn_tdst_rdy_n;
        // Flag as soon as the counter would pass MAX_BEATS, and keep flagging while it sits above it.
        long_set   = (state_q == BUSY) && ((cnt_q > CNT_MAX) || (beat && (cnt_q == CNT_MAX)));
        done_set   = !trn_tdst_rdy_n && ((req_done & ~owner_mask) != '0);
    end

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_go)     state_d = BUSY;
            BUSY:    if (release_go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_long_q <= 1'b0;
            err_done_q <= 1'b0;
        end else begin
            if (arb_go) begin
                grant_q <= NUM_REQ'(1) << win;
                sel_q   <= win;
                ptr_q   <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                cnt_q   <= '0;
            end else if (release_go) begin
                grant_q <= '0;
            end
            if (beat && (cnt_q != CNT_SAT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            err_long_q <= long_set | (err_long_q & ~err_clr);
            err_done_q <= done_set | (err_done_q & ~err_clr);
        end
    end

    // rst also masks the outputs so they are idle within the reset cycle itself.
    always_comb begin
        req_stall      = trn_tdst_rdy_n;
        req_grant      = rst ? '0 : grant_q;
        err_long       = err_long_q & ~rst;
        err_done       = err_done_q & ~rst;
        trn_td         = '0;
        trn_trem_n     = 8'hFF;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        if ((state_q == BUSY) && !rst) begin
            trn_td         = req_td[int'(sel_q)*64 +: 64];
            trn_trem_n     = req_trem_n[int'(sel_q)*8 +: 8];
            trn_tsof_n     = req_tsof_n[sel_q];
            trn_teof_n     = req_teof_n[sel_q];
            trn_tsrc_rdy_n = req_tsrc_rdy_n[sel_q];
        end
    end

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Bench for pcie_tx_arb: behavioural packet engines, a reference arbiter model and a
// scoreboard monitor that checks grants, forwarded beats, idle outputs and error flags.
module tb_pcie_tx_arb;

    localparam int N    = 3;
    localparam int MAXB = 4;

    logic             pcie_clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_v, req_done, req_grant;
    logic             req_stall;
    logic [N*64-1:0]  req_td;
    logic [N*8-1:0]   req_trem_n;
    logic [N-1:0]     req_tsof_n, req_teof_n, req_tsrc_rdy_n;
    logic [63:0]      trn_td;
    logic [7:0]       trn_trem_n;
    logic             trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n;
    logic [5:0]       trn_tbuf_av;
    logic             err_long, err_done, err_clr;

    always #5 pcie_clk = ~pcie_clk;

    pcie_tx_arb #(.NUM_REQ(N), .MAX_BEATS(MAXB)) dut (
        .pcie_clk(pcie_clk), .rst(rst),
        .req_v(req_v), .req_done(req_done), .req_grant(req_grant), .req_stall(req_stall),
        .req_td(req_td), .req_trem_n(req_trem_n), .req_tsof_n(req_tsof_n),
        .req_teof_n(req_teof_n), .req_tsrc_rdy_n(req_tsrc_rdy_n),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
        .err_long(err_long), .err_done(err_done), .err_clr(err_clr)
    );

    typedef struct packed { int idx; int cyc; } gexp_t;
    typedef struct packed { logic [63:0] td; logic [7:0] trem; logic sof; logic eof; } beat_t;

    gexp_t gq[$];
    beat_t bq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    // reference model state
    bit m_busy;
    int m_sel, m_ptr, m_beats;
    bit e_long, e_done;

    // packet engine state and knobs
    int plen[N];
    int sent[N];
    bit gen_en[N];
    int len_lo, len_hi, gen_pct, bubble_pct, stall_pct, drop_pct, tbz_pct;

    always @(posedge pcie_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Arbiter behaviour from its rules, evaluated on the values sampled at the last edge.
    task automatic model_step();
        bit stall, sl, sd;
        int w;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_beats = 0; e_long = 0; e_done = 0;
            gq.delete();
            return;
        end
        stall = trn_tdst_rdy_n;
        sl = 0; sd = 0; w = 0;
        for (int i = 0; i < N; i++)
            if (req_done[i] && !stall && !(m_busy && i == m_sel)) sd = 1;
        if (m_busy) begin
            if (!stall && !req_tsrc_rdy_n[m_sel]) m_beats++;
            if (m_beats > MAXB) sl = 1;
            if (req_done[m_sel] && !stall) m_busy = 0;
        end else if (req_v != 0 && trn_tbuf_av != 0) begin
            for (int k = 0; k < N; k++) begin
                if (req_v[(m_ptr + k) % N]) begin
                    w = (m_ptr + k) % N;
                    break;
                end
            end
            gq.push_back('{idx: w, cyc: cyc});
            m_busy = 1; m_sel = w; m_ptr = (w + 1) % N; m_beats = 0;
        end
        e_long = sl | (e_long & !err_clr);
        e_done = sd | (e_done & !err_clr);
    endtask

    task automatic engines_step();
        bit stall_prev, valid_prev, done_prev, hold, last;
        beat_t b;
        stall_prev = trn_tdst_rdy_n;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                plen[i] = 0; sent[i] = 0;
                req_v[i] = 0; req_done[i] = 0; req_tsrc_rdy_n[i] = 1;
                req_tsof_n[i] = 1; req_teof_n[i] = 1;
                continue;
            end
            valid_prev = !req_tsrc_rdy_n[i];
            done_prev  = req_done[i];
            hold = valid_prev && stall_prev;
            if (valid_prev && !stall_prev) begin
                sent[i]++;
                if (done_prev) begin plen[i] = 0; sent[i] = 0; end
            end
            if (plen[i] == 0 && gen_en[i] && $urandom_range(99, 0) < gen_pct)
                plen[i] = $urandom_range(len_hi, len_lo);
            if (hold) continue;
            req_td[i*64 +: 64]   = {$urandom, $urandom};
            req_trem_n[i*8 +: 8] = 8'($urandom);
            if (req_grant[i] && plen[i] > 0 && $urandom_range(99, 0) >= bubble_pct) begin
                last = (sent[i] == plen[i] - 1);
                req_tsrc_rdy_n[i] = 0;
                req_tsof_n[i] = (sent[i] != 0);
                req_teof_n[i] = !last;
                req_done[i]   = last;
                b.td = req_td[i*64 +: 64]; b.trem = req_trem_n[i*8 +: 8];
                b.sof = req_tsof_n[i]; b.eof = req_teof_n[i];
                bq.push_back(b);
            end else begin
                req_tsrc_rdy_n[i] = 1; req_done[i] = 0;
                req_tsof_n[i] = 1'($urandom); req_teof_n[i] = 1'($urandom);
            end
            req_v[i] = (plen[i] > 0) && !(req_grant[i] && $urandom_range(99, 0) < drop_pct);
        end
    endtask

    task automatic cycle();
        @(posedge pcie_clk);
        #1;
        model_step();
        engines_step();
        trn_tdst_rdy_n = ($urandom_range(99, 0) < stall_pct);
        trn_tbuf_av = ($urandom_range(99, 0) < tbz_pct) ? 6'd0 : 6'($urandom_range(63, 1));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain();
        int t;
        t = 0;
        for (int i = 0; i < N; i++) gen_en[i] = 0;
        stall_pct = 0; tbz_pct = 0;
        while ((plen[0] + plen[1] + plen[2]) > 0 && t < 300) begin cycle(); t++; end
        if (t >= 300) fail("drain_timeout", "packets still pending");
        run(3);
    endtask

    task automatic wait_grant(input int i);
        int t;
        t = 0;
        while (!req_grant[i] && t < 60) begin cycle(); t++; end
        if (!req_grant[i]) fail("wait_grant_timeout", $sformatf("no grant to %0d", i));
    endtask

    task automatic set_gen(input bit g0, input bit g1, input bit g2);
        gen_en[0] = g0; gen_en[1] = g1; gen_en[2] = g2;
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    logic [N-1:0] prev_g = '0;
    always @(negedge pcie_clk) begin
        gexp_t e;
        beat_t b;
        if (rst) begin
            chk("rst_grant", req_grant, 0);
            chk("rst_tsrc_rdy_n", trn_tsrc_rdy_n, 1);
            chk("rst_errors", {err_long, err_done}, 0);
            gq.delete();
            bq.delete();
            prev_g = '0;
        end else begin
            chk("stall_passthru", req_stall, trn_tdst_rdy_n);
            if (gq.size() > 0 && gq[0].cyc < cyc) begin
                e = gq.pop_front();
                fail("grant_missing", $sformatf("expected grant to %0d at cycle %0d", e.idx, e.cyc));
            end
            if (req_grant != 0 && prev_g == 0) begin
                if (gq.size() == 0) fail("grant_unexpected", $sformatf("got grant %b", req_grant));
                else begin
                    e = gq.pop_front();
                    chk("grant_idx", req_grant, 64'(N'(1) << e.idx));
                    chk("grant_cycle", cyc, e.cyc);
                end
            end else if (req_grant != 0 && req_grant != prev_g) begin
                fail("grant_changed", $sformatf("got %b after %b", req_grant, prev_g));
            end
            if (req_grant == 0) begin
                chk("idle_td", trn_td, 0);
                chk("idle_ctrl", {trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, {8'hFF, 3'b111});
            end
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                if (bq.size() == 0) fail("beat_unexpected", $sformatf("td %0h", trn_td));
                else begin
                    b = bq.pop_front();
                    chk("beat_td", trn_td, b.td);
                    chk("beat_ctrl", {trn_trem_n, trn_tsof_n, trn_teof_n}, {b.trem, b.sof, b.eof});
                end
            end
            chk("err_long", err_long, e_long);
            chk("err_done", err_done, e_done);
            prev_g = req_grant;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req_v = '0; req_done = '0; req_tsrc_rdy_n = '1; req_tsof_n = '1; req_teof_n = '1;
        req_td = '0; req_trem_n = '1; trn_tdst_rdy_n = 0; trn_tbuf_av = 6'd8; err_clr = 0;
        for (int i = 0; i < N; i++) begin plen[i] = 0; sent[i] = 0; gen_en[i] = 0; end
        len_lo = 4; len_hi = 4; gen_pct = 100; bubble_pct = 0; stall_pct = 0; drop_pct = 0; tbz_pct = 0;
        m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0; e_long = 0; e_done = 0;
        run(3);
        rst = 0;

        // single requester 1, 4-beat TLPs, no stall
        set_gen(0, 1, 0);
        run(40);
        drain();

        // all three requesting, 2-beat TLPs: rotation 0,1,2,...
        len_lo = 2; len_hi = 2;
        set_gen(1, 1, 1);
        run(60);
        drain();

        // randomized traffic with stalls, bubbles, req_v drops and empty TX buffer
        len_lo = 1; len_hi = 4; gen_pct = 50; bubble_pct = 20; drop_pct = 10;
        set_gen(1, 1, 1);
        for (int r = 0; r < 1500; r++) begin
            stall_pct = 25; tbz_pct = 15;
            cycle();
        end
        drain();

        // no buffer space: nothing granted, then grants resume
        gen_pct = 100; bubble_pct = 0; drop_pct = 0;
        set_gen(1, 1, 1);
        for (int r = 0; r < 10; r++) begin tbz_pct = 100; cycle(); end
        chk("no_grant_without_tbuf", req_grant, 0);
        tbz_pct = 0;
        run(20);
        drain();

        // exactly MAX_BEATS beats with stalls and bubbles must not flag
        len_lo = MAXB; len_hi = MAXB; bubble_pct = 30;
        set_gen(1, 1, 1);
        for (int r = 0; r < 80; r++) begin stall_pct = 30; cycle(); end
        drain();
        chk("max_beats_no_err_long", err_long, 0);

        // overlong TLP: flag set, TLP completes, flag sticky until cleared
        len_lo = 6; len_hi = 6; bubble_pct = 0;
        set_gen(1, 0, 0);
        wait_grant(0);
        gen_en[0] = 0;
        drain();
        chk("err_long_sticky", err_long, 1);
        err_clr = 1; cycle(); err_clr = 0; cycle();
        chk("err_long_cleared", err_long, 0);

        // stray done from a non-granted requester
        len_lo = 4; len_hi = 4;
        set_gen(1, 0, 0);
        wait_grant(0);
        req_done[2] = 1;
        cycle();
        chk("err_done_stray", err_done, 1);
        drain();

        // clear and a set condition in the same cycle: set wins
        err_clr = 1; req_done[1] = 1;
        cycle();
        err_clr = 0;
        chk("err_set_wins", err_done, 1);
        err_clr = 1; cycle(); err_clr = 0; cycle();
        chk("err_done_cleared", err_done, 0);

        // reset in the middle of a TLP from requester 1, with err_done set
        set_gen(0, 1, 0);
        wait_grant(1);
        req_done[0] = 1;
        for (int t = 0; t < 20 && sent[1] < 2; t++) cycle();
        rst = 1;
        cycle();
        set_gen(0, 1, 1);
        rst = 0;
        #1;
        chk("post_rst_grant", req_grant, 0);
        chk("post_rst_tsrc_rdy_n", trn_tsrc_rdy_n, 1);
        chk("post_rst_errors", {err_long, err_done}, 0);
        // ptr back at 0: requester 1 wins over 2
        wait_grant(1);
        chk("post_rst_ptr_winner", req_grant, 3'b010);
        drain();

        chk("grants_left", gq.size(), 0);
        chk("beats_left", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcie_tx_arb.md
# pcie_tx_arb

Round-robin scheduler that shares the PCIe core's single 64-bit TRN transmit interface between `NUM_REQ` packet engines (completion, DMA-read request, DMA-write request). It runs the `pcie_req_v` / `pcie_req_grant` / `pcie_req_stall` / `pcie_req_done` handshake with each engine. It muxes the granted engine's `trn_*` outputs onto the core and holds ownership for exactly one TLP. It also flags protocol violations (overlong packets, done without grant).

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters. Index 0 is the completion engine.
- `MAX_BEATS`, 64, maximum data beats allowed per TLP before `err_long` is raised.

Ports:
- `pcie_clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_v`  in  NUM_REQ  per-requester request (`pcie_req_v`).
- `req_done`  in  NUM_REQ  per-requester end-of-TLP (`pcie_req_done`).
- `req_grant`  out  NUM_REQ  one-hot grant (`pcie_req_grant`).
- `req_stall`  out  1  broadcast stall (`pcie_req_stall`).
- `req_td`  in  NUM_REQ*64  per-requester `trn_td`.
- `req_trem_n`  in  NUM_REQ*8  per-requester `trn_trem_n`.
- `req_tsof_n`, `req_teof_n`, `req_tsrc_rdy_n`  in  NUM_REQ each  per-requester framing signals.
- `trn_td`  out  64  to core.
- `trn_trem_n`  out  8  to core.
- `trn_tsof_n`, `trn_teof_n`, `trn_tsrc_rdy_n`  out  1 each  to core.
- `trn_tdst_rdy_n`  in  1  core destination ready (low = ready).
- `trn_tbuf_av`  in  6  core TX buffer availability.
- `err_long`  out  1  sticky: a TLP exceeded `MAX_BEATS`.
- `err_done`  out  1  sticky: `req_done` seen from a non-granted requester.
- `err_clr`  in  1  clears both sticky errors.

## Operation
- States: IDLE and BUSY.
- **IDLE:**
  - Arbitration fires when `|req_v` is high and `trn_tbuf_av != 0`.
  - The winner is the first requester with `req_v` high, searching from `ptr` upward with wrap.
  - Next cycle: `req_grant[winner]` goes high, `sel` = winner, state becomes BUSY, `ptr` = winner+1 mod `NUM_REQ`, and the beat counter clears.
  - With no eligible request, state stays IDLE and `ptr` is unchanged.
- **BUSY:**
  - The grant holds steady.
  - The beat counter increments on each cycle where `~req_stall & ~req_tsrc_rdy_n[sel]`. It saturates at `MAX_BEATS`+1.
  - Release condition: `req_done[sel] & ~req_stall`. On release, next cycle `req_grant` = 0 and state returns to IDLE.
  - Consequence: at least one idle cycle between TLPs, and a new grant comes no earlier than 2 cycles after done.
- **Stall:** `req_stall = trn_tdst_rdy_n`, passed through combinationally to all requesters.
  - A `req_done` asserted while `req_stall` is high is ignored.
  - The requester must hold its outputs during a stall.
- **Mux:**
  - In BUSY, the `trn_*` outputs are combinational copies of requester `sel`.
  - In IDLE they are forced to idle values: `trn_td`=0, `trn_trem_n`=8'hFF, `trn_tsof_n`=1, `trn_teof_n`=1, `trn_tsrc_rdy_n`=1.
- **Error flags:**
  - `err_long` sets when the beat counter exceeds `MAX_BEATS`. The grant is NOT revoked; the packet completes normally.
  - `err_done` sets when any `req_done[i]` with `i != sel` (or any `req_done` in IDLE) is high and `req_stall` is low.
  - `err_clr` clears both flags. If `err_clr` and a set condition occur in the same cycle, set wins.
- **Simultaneous events:**
  - If a requester drops `req_v` while it is granted, the grant is still held until its done.
  - `trn_tbuf_av` falling to 0 in BUSY does not affect the current TLP.
- **Reset:**
  - All outputs go to their idle values within the reset cycle: `req_grant`=0, `trn_*` at idle values, errors 0.
  - Internal: `ptr`=0, state IDLE.
  - Reset mid-packet drops the grant immediately. The truncated TLP is the requester's responsibility; the requester is reset on the same `rst`.

## Timing
- Grant latency: `req_v` high at cycle t in IDLE gives `req_grant` high at t+1.
- The requester's first beat (SOF) may appear at t+1, driven combinationally from grant.
- Data path (requester `trn_*` to core `trn_*`): zero added latency, purely combinational mux. `sel` is registered.
- Release: `req_done` accepted at cycle d gives `req_grant`=0 at d+1; the earliest next grant is at d+2.
- `req_stall` has zero latency from `trn_tdst_rdy_n`.
- Fairness: no requester waits more than `NUM_REQ`-1 TLPs while continuously requesting.

## Test plan
- Single requester 1, 4-beat TLP, no stall → grant at t+1, four beats pass unchanged to `trn_*`, grant drops 1 cycle after done, IDLE outputs are `trem_n`=FF, `tsrc_rdy_n`=1.
- All three `req_v` held high, each sending 2-beat TLPs → grant order 0,1,2,0,1,2, with 1 idle cycle between TLPs.
- `trn_tdst_rdy_n` high for 3 cycles mid-packet, with `req_done` asserted during the stall → done is ignored while stalled, the TLP ends only on the unstalled done cycle, and the beat count equals the actual beats.
- `trn_tbuf_av`=0 with requests pending → no grant. `trn_tbuf_av`=1 → grant to requester at `ptr` on the next cycle.
- `MAX_BEATS`=4 with a 6-beat TLP → `err_long`=1 after beat 5, the TLP completes, the flag stays set until `err_clr`. A stray `req_done[2]` while 0 is granted → `err_done`=1.
- `rst` asserted in BUSY mid-packet → next cycle `req_grant`=0, `trn_tsrc_rdy_n`=1, `ptr`=0, errors 0.
